sram_pixel_decoder: RTL and testbench
=====================================

# sram_pixel_decoder

Downstream consumer of the SRAM address encoder in the display path: it takes the same pixel-index stream that feeds the encoder and captures the 16-bit SRAM read word the encoder's address selects. It then extracts the 4-bit pixel nibble and maps it through a writable 16-entry palette to 24-bit RGB for the VGA output stage. Pipeline alignment with the encoder's one-cycle registered address is internal to this block.

## Interface
Parameters:
- MAX_PIXELS, 307200, pixel-index range; indices at or above this value decode as black and transparent.
- TRANSPARENT_IDX, 0, palette index flagged as transparent.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_pixel_valid  in  1  index on i_object_pixel_index is live this cycle.
- i_object_pixel_index  in  21  index presented to the encoder in the same cycle.
- i_sram_dq  in  16  SRAM read data, valid during the cycle after the index is presented.
- i_pal_we  in  1  palette write strobe.
- i_pal_addr  in  4  palette entry to write.
- i_pal_data  in  24  palette data, {R[7:0], G[7:0], B[7:0]}.
- o_pixel_valid  out  1  RGB output is valid.
- o_vga_r / o_vga_g / o_vga_b  out  8 each  pixel colour.
- o_transparent  out  1  pixel nibble equals TRANSPARENT_IDX, or the index was out of range.

## Operation
- Word layout: pixel k of a word, where k = index[1:0], occupies i_sram_dq[4k+3:4k].
- Stage 0 (cycle t): register valid, index[1:0], and out_of_range = (index >= MAX_PIXELS).
- Stage 1 (cycle t+1): SRAM data for index t is on i_sram_dq. Register the word, plus the stage-0 valid, sel and range signals.
- Stage 2 (cycle t+2): select the nibble with the delayed sel. Register the palette lookup result into the outputs, along with valid and transparent.
- Out-of-range handling: RGB forced to 0 and o_transparent forced to 1. Valid still propagates.
- Invalid slots: when the stage-2 valid is 0, outputs hold 0 and o_transparent is 0.
- Palette default at reset: entry i has R=G=B=i*17 (grayscale; 0x00 through 0xFF).
- Palette write: when i_pal_we is high at edge e, the entry updates at e.
- Simultaneous write and lookup of the same entry in the same edge: the lookup returns the old value (read-before-write).
- Writes are accepted regardless of valid.
- No backpressure. The stream is accepted every cycle.

## Timing
- Latency: index and valid at edge t map to o_pixel_valid/RGB at edge t+3, i.e. outputs valid during cycle t+3.
- Throughput is 1 pixel per cycle. Back-to-back indices sharing a word each re-sample i_sram_dq; there is no word caching.
- Reset (asynchronous, any time, including mid-stream): all pipeline valids, word register and outputs go to 0, and the palette returns to default.
- After i_rst_n deasserts, the first valid output can appear at edge 3 at the earliest.
- Reset values: o_pixel_valid=0, o_vga_r/g/b=0, o_transparent=0.
- Widths: the range compare is 21-bit unsigned. Nibble select is a 2-bit mux. There is no arithmetic overflow path.

## Structure
- Shared package sram_pkg holds:
  - PIXEL_BITS=4, PIXELS_PER_WORD=4, SRAM_DATA_W=16, SRAM_ADDR_W=20, PIX_IDX_W=21;
  - typedef rgb_t as a packed struct {r, g, b}, 8 bits each;
  - the pipeline-latency constant DECODE_LAT=3, shared with the encoder-side sync logic.
- One sub-module, sram_palette_ram: 16×24 register file with the reset default, one write port and one registered read port, read-before-write.
- Top level holds: the stage registers, nibble mux and range logic.

## Test plan
- Reset defaults: hold i_rst_n low for 5 cycles and release, then stream index 0x3 with i_sram_dq=0xA000. Expect nibble 0xA at t+3: RGB=(0xAA,0xAA,0xAA), o_transparent=0.
- Nibble order: indices 4, 5, 6, 7 back-to-back, each with i_sram_dq=0x4321. Expect RGB 0x11, 0x22, 0x33, 0x44 gray on consecutive cycles, o_pixel_valid held high for 4 cycles.
- Transparency and palette write:
  - Write entry 5 = 0xFF0000, then stream a pixel with nibble 5. Expect RGB=(0xFF,0x00,0x00).
  - A pixel with nibble 0 asserts o_transparent=1.
- Read-before-write: a lookup of entry 5 in the same edge as a write of 0x00FF00 to entry 5 returns the old 0xFF0000; the next pixel returns 0x00FF00.
- Range: index 307199 decodes normally. Index 307200 gives o_pixel_valid=1, RGB=0, o_transparent=1.
- Reset mid-stream: a continuous valid stream with i_rst_n pulsed low asynchronously mid-cycle.
  - Outputs go to 0 immediately, and no stale pixel emerges after release.
  - The palette is back to default grayscale.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM pixel path (address encoder and pixel decoder).
// Holds the word/pixel geometry, the RGB struct and the encoder-to-output latency.
package sram_pkg;

    localparam int unsigned PIXEL_BITS      = 4;
    localparam int unsigned PIXELS_PER_WORD = 4;
    localparam int unsigned SRAM_DATA_W     = 16;
    localparam int unsigned SRAM_ADDR_W     = 20;
    localparam int unsigned PIX_IDX_W       = 21;
    localparam int unsigned PAL_ENTRIES     = 16;

    // Index/valid in to RGB out, in clock edges; the encoder-side sync logic relies on it.
    localparam int unsigned DECODE_LAT      = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Grayscale ramp: i*17 equals the nibble repeated in both halves of the byte.
    function automatic rgb_t pal_default(input logic [3:0] idx);
        logic [7:0] v;
        v = {idx, idx};
        return '{r: v, g: v, b: v};
    endfunction

endpackage

// File: rtl/sram_palette_ram.sv
// 16 x 24-bit palette register file.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset (restores grayscale ramp)
//   we_i/waddr_i/wdata_i  write port, entry updates at the clock edge
//   re_i/raddr_i        registered read; rdata_o is 0 on cycles without a read
//   rdata_o             {R, G, B} of the entry read at the previous edge
// A read and write of the same entry at one edge returns the old contents.
module sram_palette_ram
    import sram_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [3:0]  waddr_i,
    input  logic [23:0] wdata_i,
    input  logic        re_i,
    input  logic [3:0]  raddr_i,
    output logic [23:0] rdata_o
);

    rgb_t mem_q [PAL_ENTRIES];
    rgb_t rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(PAL_ENTRIES); i++) begin
                mem_q[i] <= pal_default(4'(i));
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Samples mem_q before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_pixel_decoder.sv
// Pixel decoder behind the SRAM address encoder: captures the SRAM word for each pixel
// index, extracts the 4-bit nibble and maps it through the palette to 24-bit RGB.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_pixel_valid           index on i_object_pixel_index is live
//   i_object_pixel_index    pixel index (same one fed to the encoder)
//   i_sram_dq               SRAM read word, valid the cycle after the index
//   i_pal_we/addr/data      palette write port
//   o_pixel_valid, o_vga_*  pixel colour, DECODE_LAT edges after the index is sampled
//   o_transparent           nibble == TRANSPARENT_IDX, or index out of range
module sram_pixel_decoder
    import sram_pkg::*;
#(
    parameter int unsigned MAX_PIXELS      = 307200,
    parameter int unsigned TRANSPARENT_IDX = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_pixel_valid,
    input  logic [PIX_IDX_W-1:0]   i_object_pixel_index,
    input  logic [SRAM_DATA_W-1:0] i_sram_dq,
    input  logic                   i_pal_we,
    input  logic [3:0]             i_pal_addr,
    input  logic [23:0]            i_pal_data,
    output logic                   o_pixel_valid,
    output logic [7:0]             o_vga_r,
    output logic [7:0]             o_vga_g,
    output logic [7:0]             o_vga_b,
    output logic                   o_transparent
);

    localparam logic [PIXEL_BITS-1:0] TranspNib = PIXEL_BITS'(TRANSPARENT_IDX);

    // Stage 0: index sampled alongside the encoder's address register.
    logic       s0_valid_q;
    logic [1:0] s0_sel_q;
    logic       s0_oor_q;
    logic       s0_oor_d;

    // Stage 1: SRAM word for the stage-0 index.
    logic                   s1_valid_q;
    logic [1:0]             s1_sel_q;
    logic                   s1_oor_q;
    logic [SRAM_DATA_W-1:0] s1_word_q;

    // Stage 2: output flags; colour comes straight from the palette read register.
    logic s2_valid_q;
    logic s2_tr_q;
    logic s2_tr_d;

    logic [PIXEL_BITS-1:0] nibble;
    logic                  pal_re;
    rgb_t                  pal_rgb;

    assign s0_oor_d = (32'(i_object_pixel_index) >= MAX_PIXELS);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s0_valid_q <= 1'b0;
            s0_sel_q   <= '0;
            s0_oor_q   <= 1'b0;
        end else begin
            s0_valid_q <= i_pixel_valid;
            s0_sel_q   <= i_object_pixel_index[1:0];
            s0_oor_q   <= s0_oor_d;
        end
    end

    // The word is captured every cycle; pixels sharing a word never reuse a stale copy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sel_q   <= '0;
            s1_oor_q   <= 1'b0;
            s1_word_q  <= '0;
        end else begin
            s1_valid_q <= s0_valid_q;
            s1_sel_q   <= s0_sel_q;
            s1_oor_q   <= s0_oor_q;
            s1_word_q  <= i_sram_dq;
        end
    end

    always_comb begin
        nibble = '0;
        unique case (s1_sel_q)
            2'd0: nibble = s1_word_q[3:0];
            2'd1: nibble = s1_word_q[7:4];
            2'd2: nibble = s1_word_q[11:8];
            2'd3: nibble = s1_word_q[15:12];
            default: nibble = '0;
        endcase
    end

    // Skipping the read on invalid or out-of-range slots zeroes the RGB for free.
    assign pal_re  = s1_valid_q & ~s1_oor_q;
    assign s2_tr_d = s1_valid_q & (s1_oor_q | (nibble == TranspNib));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_valid_q <= 1'b0;
            s2_tr_q    <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_tr_q    <= s2_tr_d;
        end
    end

    sram_palette_ram u_palette (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .we_i    (i_pal_we),
        .waddr_i (i_pal_addr),
        .wdata_i (i_pal_data),
        .re_i    (pal_re),
        .raddr_i (nibble),
        .rdata_o (pal_rgb)
    );

    assign o_pixel_valid = s2_valid_q;
    assign o_vga_r       = pal_rgb.r;
    assign o_vga_g       = pal_rgb.g;
    assign o_vga_b       = pal_rgb.b;
    assign o_transparent = s2_tr_q;

endmodule

// File: tb/tb_sram_pixel_decoder.sv
// Scoreboard bench for sram_pixel_decoder: each valid pixel pushes its nibble/range and
// due cycle; the monitor pops on o_pixel_valid and derives RGB from a palette model.
module tb_sram_pixel_decoder;

    localparam int unsigned MAX_PIX = 307200;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_pixel_valid;
    logic [20:0] i_object_pixel_index;
    logic [15:0] i_sram_dq;
    logic        i_pal_we;
    logic [3:0]  i_pal_addr;
    logic [23:0] i_pal_data;
    logic        o_pixel_valid;
    logic [7:0]  o_vga_r;
    logic [7:0]  o_vga_g;
    logic [7:0]  o_vga_b;
    logic        o_transparent;

    sram_pixel_decoder #(
        .MAX_PIXELS      (MAX_PIX),
        .TRANSPARENT_IDX (0)
    ) dut (
        .i_clk                (i_clk),
        .i_rst_n              (i_rst_n),
        .i_pixel_valid        (i_pixel_valid),
        .i_object_pixel_index (i_object_pixel_index),
        .i_sram_dq            (i_sram_dq),
        .i_pal_we             (i_pal_we),
        .i_pal_addr           (i_pal_addr),
        .i_pal_data           (i_pal_data),
        .o_pixel_valid        (o_pixel_valid),
        .o_vga_r              (o_vga_r),
        .o_vga_g              (o_vga_g),
        .o_vga_b              (o_vga_b),
        .o_transparent        (o_transparent)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        oor;
        logic [3:0]  nib;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb_q [$];
    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] cyc = 0;
    logic [15:0] dq_pend = '0;
    logic [23:0] pal_m    [16];
    logic [23:0] pal_prev [16];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // Palette model; pal_prev is the contents seen by a lookup at the latest edge.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 16; i++) begin
                pal_m[i]    = {3{8'(i * 17)}};
                pal_prev[i] = {3{8'(i * 17)}};
            end
        end else begin
            pal_prev = pal_m;
            if (i_pal_we) pal_m[i_pal_addr] = i_pal_data;
        end
    end

    always @(negedge i_clk) begin
        exp_t        e;
        logic [23:0] exp_rgb;
        logic        exp_tr;
        if (o_pixel_valid) begin
            if (sb_q.size() == 0) begin
                check_val("stale_pixel", 32'(o_pixel_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                if (e.oor) begin
                    exp_rgb = '0;
                    exp_tr  = 1'b1;
                end else begin
                    exp_rgb = pal_prev[e.nib];
                    exp_tr  = (e.nib == 4'd0);
                end
                check_val("latency", cyc, e.cyc);
                check_val("rgb", 32'({o_vga_r, o_vga_g, o_vga_b}), 32'(exp_rgb));
                check_val("transparent", 32'(o_transparent), 32'(exp_tr));
            end
        end else begin
            check_val("idle_rgb", 32'({o_vga_r, o_vga_g, o_vga_b}), 32'd0);
            check_val("idle_transparent", 32'(o_transparent), 32'd0);
        end
    end

    function automatic logic [3:0] nib_of(input logic [20:0] idx, input logic [15:0] dq);
        logic [15:0] sh;
        sh = dq >> {idx[1:0], 2'b00};
        return sh[3:0];
    endfunction

    // One cycle of stimulus; the SRAM word trails its index by one cycle.
    task automatic slot(input logic v, input logic [20:0] idx, input logic [15:0] dq,
                        input logic we = 1'b0, input logic [3:0] wa = '0,
                        input logic [23:0] wd = '0);
        exp_t e;
        @(posedge i_clk);
        #1;
        i_pixel_valid        = v;
        i_object_pixel_index = idx;
        i_sram_dq            = dq_pend;
        dq_pend              = dq;
        i_pal_we             = we;
        i_pal_addr           = wa;
        i_pal_data           = wd;
        if (v && i_rst_n) begin
            e.oor = ({11'b0, idx} >= MAX_PIX);
            e.nib = nib_of(idx, dq);
            e.cyc = cyc + 3;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) slot(1'b0, '0, '0);
    endtask

    task automatic release_reset();
        @(posedge i_clk);
        #1;
        i_rst_n       = 1'b1;
        i_pixel_valid = 1'b0;
        i_pal_we      = 1'b0;
    endtask

    initial begin
        i_rst_n              = 1'b0;
        i_pixel_valid        = 1'b0;
        i_object_pixel_index = '0;
        i_sram_dq            = '0;
        i_pal_we             = 1'b0;
        i_pal_addr           = '0;
        i_pal_data           = '0;
        repeat (5) @(posedge i_clk);
        #1;
        check_val("rst_valid", 32'(o_pixel_valid), 32'd0);
        check_val("rst_rgb", 32'({o_vga_r, o_vga_g, o_vga_b}), 32'd0);
        check_val("rst_transparent", 32'(o_transparent), 32'd0);
        release_reset();

        // Reset palette, pixel 3 of the word -> 0xAA gray.
        slot(1'b1, 21'd3, 16'hA000);
        idle(4);

        // Nibble order within a word, back-to-back.
        for (int i = 4; i < 8; i++) slot(1'b1, 21'(i), 16'h4321);
        idle(4);

        // Palette write then use; nibble 0 is transparent.
        slot(1'b0, '0, '0, 1'b1, 4'd5, 24'hFF0000);
        idle(1);
        slot(1'b1, 21'd8, 16'h0005);
        slot(1'b1, 21'd9, 16'h0000);
        idle(4);

        // First pixel's lookup shares an edge with the write of entry 5.
        slot(1'b1, 21'd8, 16'h0005);
        slot(1'b1, 21'd8, 16'h0005);
        slot(1'b1, 21'd8, 16'h0005, 1'b1, 4'd5, 24'h00FF00);
        idle(4);

        // Range boundary.
        slot(1'b1, 21'd307199, 16'h7000);
        slot(1'b1, 21'd307200, 16'h7000);
        slot(1'b1, 21'h1FFFFF, 16'h7000);
        idle(4);

        // Reset in the middle of a continuous stream.
        for (int i = 0; i < 6; i++) begin
            slot(1'b1, 21'($urandom_range(0, 320000)), 16'($urandom));
        end
        #3;
        check_val("pre_rst_valid", 32'(o_pixel_valid), 32'd1);
        i_rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(o_pixel_valid), 32'd0);
        check_val("mid_rst_rgb", 32'({o_vga_r, o_vga_g, o_vga_b}), 32'd0);
        check_val("mid_rst_transparent", 32'(o_transparent), 32'd0);
        sb_q.delete();
        for (int i = 0; i < 3; i++) slot(1'b1, 21'(i), 16'h5555);
        release_reset();
        // Entry 5 must be back to 0x555555.
        slot(1'b1, 21'd1, 16'h0050);
        for (int i = 0; i < 8; i++) begin
            slot(1'b1, 21'($urandom_range(0, 320000)), 16'($urandom));
        end
        idle(6);
        check_val("drain", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
